// File: rtl/line_fill_buffer_pkg.sv
`default_nettype none
// line_fill_buffer_pkg: shared cache-line geometry and fill FSM state type.
// Rev 1.0
package line_fill_buffer_pkg;

  localparam int LFB_WORD_W     = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/line_fill_buffer.sv
`default_nettype none
// line_fill_buffer: assembles a 4-word line from memory beats and forwards the critical word.
// Define LINE_FILL_CWF_EN for critical-word-first fill order.  Rev 1.0
module line_fill_buffer
  import line_fill_buffer_pkg::*;
#(
  parameter int WORD_W = LFB_WORD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [OFFSET_W-1:0]        start_word,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_data,
  output logic                       crit_valid,
  output logic [WORD_W-1:0]          crit_data,
  output logic                       line_valid,
  input  logic                       line_ready,
  output logic [WORDS_PER_LINE*WORD_W-1:0] line_data,
  output logic                       busy
);

  state_t              state;
  logic [OFFSET_W-1:0] idx;
  logic [OFFSET_W-1:0] count;
  logic [OFFSET_W-1:0] start_idx;

`ifdef LINE_FILL_CWF_EN
  assign start_idx = start_word;
`else
  logic unused_start_word;
  assign start_idx         = '0;
  assign unused_start_word = ^start_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      count      <= '0;
      in_ready   <= 1'b0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      line_valid <= 1'b0;
      line_data  <= '0;
      busy       <= 1'b0;
    end else begin
      crit_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FILL;
            idx       <= start_idx;
            count     <= '0;
            line_data <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_FILL: begin
          if (in_valid && in_ready) begin
            // Slot write decode mirrors the word-select read mux.
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
              if (idx == OFFSET_W'(k)) begin
                line_data[k*WORD_W +: WORD_W] <= in_data;
              end
            end
            idx   <= idx + OFFSET_W'(1);
            count <= count + OFFSET_W'(1);
            if (count == '0) begin
              crit_valid <= 1'b1;
              crit_data  <= in_data;
            end
            if (count == OFFSET_W'(WORDS_PER_LINE - 1)) begin
              state      <= ST_HOLD;
              in_ready   <= 1'b0;
              line_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (line_ready) begin
            state      <= ST_IDLE;
            line_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready   <= 1'b0;
          line_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_fill_buffer.sv
`default_nettype none
// tb_line_fill_buffer: randomized fills checked against a slot-placement reference model.
// Rev 1.0
module tb_line_fill_buffer;

  localparam int W  = 32;
  localparam int LW = 4 * W;
`ifdef LINE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    start_word = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          line_ready = 1'b0;
  logic          in_ready;
  logic          crit_valid;
  logic [W-1:0]  crit_data;
  logic          line_valid;
  logic [LW-1:0] line_data;
  logic          busy;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  last_crit = '0;

  line_fill_buffer #(.WORD_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_word (start_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_crit_valid"}, crit_valid, 0);
    check({tag, "_crit_data"},  crit_data,  0);
    check({tag, "_line_valid"}, line_valid, 0);
    check({tag, "_line_data"},  line_data,  0);
    check({tag, "_busy"},       busy,       0);
  endtask

  // Beat i of a fill lands in slot (first + i) mod 4; first is start_word only with CWF.
  task automatic run_fill(input logic [1:0] sw,
                          input logic [W-1:0] b0, input logic [W-1:0] b1,
                          input logic [W-1:0] b2, input logic [W-1:0] b3,
                          input int gmin, input int gmax, input int hold);
    logic [W-1:0]  beats [4];
    logic [LW-1:0] exp_line;
    int            first;
    beats    = '{b0, b1, b2, b3};
    first    = CWF ? int'(sw) : 0;
    exp_line = '0;
    for (int i = 0; i < 4; i++) exp_line[((first + i) % 4) * W +: W] = beats[i];

    start = 1'b1; start_word = sw; in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("fill_busy",     busy,      1);
    check("fill_in_ready", in_ready,  1);
    check("fill_cleared",  line_data, 0);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        check("gap_line_valid", line_valid, 0);
        check("gap_crit_valid", crit_valid, 0);
        check("gap_crit_data",  crit_data,  last_crit);
        check("gap_in_ready",   in_ready,   1);
      end
      in_valid = 1'b1; in_data = beats[i];
      @(negedge clk);
      in_valid = 1'b0;
      if (i == 0) last_crit = beats[0];
      check("beat_crit_valid", crit_valid, (i == 0));
      check("beat_crit_data",  crit_data,  last_crit);
      check("beat_line_valid", line_valid, (i == 3));
      check("beat_in_ready",   in_ready,   (i != 3));
    end
    check("line_data", line_data, exp_line);

    repeat (hold) begin
      line_ready = 1'b0; start = 1'($urandom_range(0, 1)); in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      check("hold_line_data",  line_data,  exp_line);
      check("hold_in_ready",   in_ready,   0);
      check("hold_line_valid", line_valid, 1);
      check("hold_crit_valid", crit_valid, 0);
    end
    in_valid = 1'b0; line_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    line_ready = 1'b0; start = 1'b0;
    check("drain_line_valid", line_valid, 0);
    check("drain_busy",       busy,       0);
    check("drain_in_ready",   in_ready,   0);
    @(negedge clk);
    check("handoff_start_ignored", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_fill(2'd2, 32'hA, 32'hB, 32'hC, 32'hD, 0, 0, 1);
    run_fill(2'd3, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 1);
    run_fill(2'd1, 32'h11, 32'h22, 32'h33, 32'h44, 2, 2, 5);

    // Abort a fill after two beats with an asynchronous reset.
    start = 1'b1; start_word = 2'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
      in_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    last_crit = '0;
    @(negedge clk);
    run_fill(2'd0, 32'h5, 32'h6, 32'h7, 32'h8, 1, 2, 0);

    for (int n = 0; n < 20; n++) begin
      run_fill(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
               0, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
